i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S receiver for audio capture from an external stereo ADC (Pmod I2S2-class, slave mode). It oversamples the externally supplied bit clock, word-select and serial data on the 100 MHz system clock. It deserializes each left/right word pair MSB-first and presents one stereo frame per audio sample on a valid/ready interface. It is the receive counterpart of the existing transmit path that drives `tx_mclk`/`tx_sclk`. The ADC is clocked from that path, so `rx_sclk` is nominally the same 64·fs bit clock, but this block treats it as asynchronous.

## Interface
- `DATA_WIDTH`, 24: bits captured per channel word.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchronizer (minimum 2).

- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `rx_sclk` in 1: I2S bit clock, asynchronous. Frequency must not exceed clk/4.
- `rx_lrck` in 1: word select, asynchronous; 0 = left, 1 = right.
- `rx_sdin` in 1: serial data, asynchronous.
- `left_data` out DATA_WIDTH: left sample, two's complement.
- `right_data` out DATA_WIDTH: right sample, two's complement.
- `valid` out 1: frame available.
- `ready` in 1: consumer accepts the frame.
- `overrun` out 1: one-cycle pulse when an unaccepted frame is overwritten.
- `frame_err` out 1: one-cycle pulse when a channel slot is shorter than DATA_WIDTH bits.

## Operation
- **Synchronization:** each of `rx_sclk`, `rx_lrck` and `rx_sdin` passes through its own SYNC_STAGES synchronizer. A rise tick is asserted for one clk when the synchronized sclk is 1 and its previous value was 0. `lrck` and `sdin` are sampled only on rise ticks.
- **Slot start:** occurs on the rise tick where the sampled lrck differs from the lrck sampled on the previous rise tick. The bit counter `k` is cleared to 0 at slot start and increments on every subsequent rise tick. It saturates at DATA_WIDTH+1.
- **Capture, I2S mode:** bits sampled at k = 1..DATA_WIDTH shift into the channel shift register MSB-first. The bit sampled at k = 0 is the LSB or padding of the previous slot and is ignored. Bits beyond DATA_WIDTH are ignored.
- **Word complete:** when k = DATA_WIDTH is captured, the word is latched into a left or right holding register according to the sampled lrck.
- **Frame assembly** uses FSM states WAIT_LEFT, LEFT, RIGHT:
  - After reset the FSM is in WAIT_LEFT.
  - Slot start with lrck=0 moves WAIT_LEFT → LEFT.
  - A completed left word followed by slot start with lrck=1 moves LEFT → RIGHT.
  - A completed right word publishes `left_data`/`right_data`, sets `valid`, and moves RIGHT → WAIT_LEFT.
  - A right slot seen in WAIT_LEFT is discarded silently.
- **Short slot:** slot start arrives before k reached DATA_WIDTH in LEFT or RIGHT. Response: pulse `frame_err`, discard the partial frame, move to WAIT_LEFT, then re-evaluate the new slot normally (so a left slot start enters LEFT immediately).
- **Handshake:**
  - A transfer happens in a clk cycle where `valid` and `ready` are both 1.
  - `valid` deasserts in the next cycle unless a new frame publishes in that same cycle, in which case `valid` stays 1 with the new data and no overrun.
  - Outputs are stable while `valid`=1 and `ready`=0.
  - Publishing while `valid`=1 and `ready`=0 overwrites the outputs, keeps `valid`=1, and pulses `overrun`.
- **Reset mid-operation:** all state clears immediately. Capture resumes at the next left slot start.

## Timing
- **Reset values:** `left_data`=0, `right_data`=0, `valid`=0, `overrun`=0, `frame_err`=0, FSM=WAIT_LEFT, `k`=0, synchronizers=0.
- **Rise tick latency:** the tick occurs SYNC_STAGES+1 clk after the `rx_sclk` pin edge.
- **Publish latency:** `valid`, the new data and `overrun` register 1 clk after the rise tick that captures the right word's bit DATA_WIDTH. Total pin-to-valid latency is SYNC_STAGES+2 clk.
- **`frame_err`:** asserted 1 clk after the offending slot-start tick.
- **Throughput:** one frame per lrck period. The consumer must accept within one frame period to avoid overrun.
- **Input requirements:** `rx_sdin` and `rx_lrck` must be stable at least 2 clk around the `rx_sclk` rising edge. This is met by any source that changes them on the falling sclk edge with sclk ≤ clk/4.

## Configuration
- **`I2S_RX_LEFT_JUSTIFIED_EN` defined:** left-justified format. Bits at k = 0..DATA_WIDTH−1 are captured, so the MSB is captured on the slot-start tick itself. The word completes at k = DATA_WIDTH−1, and a short slot is one where slot start arrives before k = DATA_WIDTH−1. Publish latency relative to the last data bit is unchanged.
- **Undefined:** standard I2S with one-bit delay, as described in Operation.

## Test plan
- **Nominal frame:** `ready` tied to 1, sclk period 320 ns, 32-bit slots, frame left=24'hA5A5A5, right=24'h123456. Expect `valid` high for exactly 1 clk with those values, no `overrun`, no `frame_err`.
- **Overrun:** `ready`=0 across frames (24'h000001, 24'h800000) then (24'h7FFFFF, 24'hFFFFFF). Expect one `overrun` pulse at the second publish, outputs = 24'h7FFFFF/24'hFFFFFF, `valid` held; raising `ready` drops `valid` 1 clk later.
- **Start mid-right slot:** release reset during a right slot. Expect no `valid` until the first complete left+right pair is published.
- **Short slot:** left slot of 16 sclk only. Expect one `frame_err` pulse and no `valid` for that frame; the next well-formed frame publishes correctly.
- **Reset mid-word:** assert `reset_n`=0 mid-left word while `valid`=1. Expect all outputs 0 asynchronously; the next full frame after release publishes correctly.
- **Left-justified build:** with `I2S_RX_LEFT_JUSTIFIED_EN`, drive left-justified left=24'hC00003, right=24'h3FFFFC. Expect `valid` with exactly those values.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples an external bit clock, word select and serial data on the
// system clock. It deserializes left/right words MSB-first and presents one stereo frame
// per sample on a valid/ready interface.
// Optional build macro: I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB on the slot-start bit) instead of standard I2S one-bit-delayed framing.
module i2s_rx #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_sclk,
    input  logic                  rx_lrck,
    input  logic                  rx_sdin,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun,
    output logic                  frame_err
);

    // Counter wide enough for 0..DATA_WIDTH+1 and for the wrap of (0 - 1) to exceed DATA_WIDTH.
    localparam int unsigned KW = $clog2(DATA_WIDTH + 2);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int unsigned FirstBit = 0;
`else
    localparam int unsigned FirstBit = 1;
`endif
    localparam logic [KW-1:0] KFirst = KW'(FirstBit);
    localparam logic [KW-1:0] KLast  = KW'(FirstBit + DATA_WIDTH - 1);
    localparam logic [KW-1:0] KMax   = KW'(DATA_WIDTH + 1);
    localparam logic [KW-1:0] KDw    = KW'(DATA_WIDTH);

    typedef enum logic [1:0] {StWaitLeft, StLeft, StRight} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
    logic                   sclk_prev_q, tick_q, lrck_smp_q, sdin_smp_q;
    logic                   lrck_last_q, lrck_last_d;
    logic [KW-1:0]          k_q, k_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d, left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0]  left_q, left_d, right_q, right_d;
    logic                   valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                   slot_start, capture, word_done, short_slot, publish;
    state_e                 state_q, state_d, state_eval;

    // Input synchronizers and registered rise tick with lrck/sdin sampled alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sdin_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            lrck_smp_q  <= 1'b0;
            sdin_smp_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], rx_sclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], rx_lrck};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], rx_sdin};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            tick_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            lrck_smp_q  <= lrck_sync_q[SYNC_STAGES-1];
            sdin_smp_q  <= sdin_sync_q[SYNC_STAGES-1];
        end
    end

    // Slot detection, saturating bit counter and shift register next state.
    always_comb begin
        slot_start  = tick_q && (lrck_smp_q != lrck_last_q);
        lrck_last_d = tick_q ? lrck_smp_q : lrck_last_q;
        k_d         = k_q;
        if (slot_start) begin
            k_d = '0;
        end else if (tick_q && (k_q != KMax)) begin
            k_d = k_q + KW'(1);
        end
        // Unsigned wrap makes k below KFirst fall outside the window.
        capture    = tick_q && ((k_d - KFirst) < KDw);
        shift_d    = capture ? {shift_q[DATA_WIDTH-2:0], sdin_smp_q} : shift_q;
        word_done  = tick_q && !slot_start && (k_d == KLast);
        short_slot = slot_start && (k_q < KLast);
    end

    // Frame assembly FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWaitLeft;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame assembly next state: short slots abort to WAIT_LEFT, then the new slot is judged.
    always_comb begin
        state_d     = state_q;
        state_eval  = state_q;
        frame_err_d = 1'b0;
        publish     = 1'b0;
        left_hold_d = left_hold_q;
        if (slot_start) begin
            if ((state_q != StWaitLeft) && short_slot) begin
                frame_err_d = 1'b1;
                state_eval  = StWaitLeft;
            end
            unique case (state_eval)
                StLeft:  state_d = lrck_smp_q ? StRight : StLeft;
                default: state_d = lrck_smp_q ? StWaitLeft : StLeft;
            endcase
        end else if (word_done) begin
            unique case (state_q)
                StLeft:  left_hold_d = shift_d;
                StRight: begin
                    publish = 1'b1;
                    state_d = StWaitLeft;
                end
                default: ;
            endcase
        end
    end

    // Output handshake: publish overwrites, a transfer clears valid unless a publish coincides.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (publish) begin
            left_d    = left_hold_q;
            right_d   = shift_d;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_last_q <= 1'b0;
            k_q         <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            lrck_last_q <= lrck_last_d;
            k_q         <= k_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S slots on clock-aligned pins, predicts frames at slot level
// and checks every output on every cycle, plus literal checks of the named scenarios.
module tb_i2s_rx;
    localparam int DW  = 24;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = 1;
`endif
    localparam int LAST = FIRST + DW - 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic rx_sclk = 1'b0, rx_lrck = 1'b0, rx_sdin = 1'b0, ready = 1'b0;
    logic [DW-1:0] left_data, right_data;
    logic valid, overrun, frame_err;

    int total = 0, bad = 0, cyc = 0, hp = 4, ready_mode = 1;

    typedef enum {MWait, MLeft, MRight} mst_e;
    mst_e          m_state = MWait;
    bit            m_prev_lr = 1'b0, m_prev_done = 1'b0;
    logic [DW-1:0] m_left = '0;
    logic [2*DW-1:0] pub_at [int];
    bit            ferr_at [int];
    logic          m_valid = 1'b0, e_ovr, e_ferr;
    logic [DW-1:0] m_l = '0, m_r = '0;

    int            n_valid_cyc = 0, n_ovr = 0, n_ferr = 0;
    logic [DW-1:0] seen_l = '0, seen_r = '0;
    logic          pre_valid = 1'b0;

    i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .rx_sclk(rx_sclk), .rx_lrck(rx_lrck), .rx_sdin(rx_sdin),
        .left_data(left_data), .right_data(right_data), .valid(valid), .ready(ready),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slot-level reference: what the receiver must do when a slot starts or a word completes.
    task automatic m_reset();
        m_state = MWait; m_prev_lr = 1'b0; m_prev_done = 1'b0;
        pub_at.delete(); ferr_at.delete();
    endtask

    task automatic m_slot_start(input bit ch, input int t);
        if (ch != m_prev_lr) begin
            m_prev_lr = ch;
            if (m_state != MWait && !m_prev_done) begin
                ferr_at[t + LAT] = 1'b1;
                m_state = MWait;
            end
            m_prev_done = 1'b0;
            if (!ch) m_state = MLeft;
            else m_state = (m_state == MLeft) ? MRight : MWait;
        end
    endtask

    task automatic m_word_done(input logic [DW-1:0] w, input int t);
        m_prev_done = 1'b1;
        if (m_state == MLeft) begin
            m_left = w;
        end else if (m_state == MRight) begin
            pub_at[t + LAT] = {m_left, w};
            m_state = MWait;
        end
    endtask

    // Reset pulse placed inside a low sclk phase; outputs must clear without a clock edge.
    task automatic do_reset();
        pre_valid = valid;
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", valid, 1'b0);
        check("async_left", left_data, '0);
        check("async_right", right_data, '0);
        m_reset();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic send_slot(input bit ch, input int len, input logic [DW-1:0] w,
                             input int rst_tick = -1);
        int first = 0;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            rx_sclk = 1'b0;
            rx_lrck = ch;
            rx_sdin = (j >= FIRST && j <= LAST) ? w[DW-1-(j-FIRST)] : 1'($urandom_range(0, 1));
            if (j == rst_tick) begin
                do_reset();
                first = j;
            end
            repeat (hp) @(negedge clk);
            rx_sclk = 1'b1;
            if (j == first) m_slot_start(ch, cyc);
            if (j == LAST && j >= first) m_word_done(w, cyc);
            repeat (hp - 1) @(negedge clk);
        end
    endtask

    // Per-cycle compare against the handshake model, then drive ready for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            e_ovr = 1'b0;
            e_ferr = 1'b0;
            if (!reset_n) begin
                m_valid = 1'b0; m_l = '0; m_r = '0;
            end else begin
                e_ferr = ferr_at.exists(cyc);
                if (pub_at.exists(cyc)) begin
                    e_ovr = m_valid && !ready;
                    m_valid = 1'b1;
                    {m_l, m_r} = pub_at[cyc];
                end else if (m_valid && ready) begin
                    m_valid = 1'b0;
                end
            end
            check("valid", valid, m_valid);
            check("overrun", overrun, e_ovr);
            check("frame_err", frame_err, e_ferr);
            check("left_data", left_data, m_l);
            check("right_data", right_data, m_r);
            if (valid) begin
                n_valid_cyc++; seen_l = left_data; seen_r = right_data;
            end
            if (overrun) n_ovr++;
            if (frame_err) n_ferr++;
            ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    initial begin
        int v0, o0, f0;
        logic [DW-1:0] wl, wr;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_left", left_data, '0);
        check("rst_right", right_data, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        #2 reset_n = 1'b1;

        // Nominal frame at 320 ns sclk, ready tied high.
        hp = 16; ready_mode = 1;
        v0 = n_valid_cyc; o0 = n_ovr; f0 = n_ferr;
        send_slot(1'b1, 32, DW'($urandom));
        send_slot(1'b0, 32, 24'hA5A5A5);
        send_slot(1'b1, 32, 24'h123456);
        check("nom_valid_cycles", n_valid_cyc - v0, 1);
        check("nom_left", seen_l, 24'hA5A5A5);
        check("nom_right", seen_r, 24'h123456);
        check("nom_overruns", n_ovr - o0, 0);
        check("nom_frame_errs", n_ferr - f0, 0);

        // Overrun: two frames with ready low.
        hp = 4; ready_mode = 0; o0 = n_ovr;
        send_slot(1'b0, 32, 24'h000001);
        send_slot(1'b1, 32, 24'h800000);
        send_slot(1'b0, 32, 24'h7FFFFF);
        send_slot(1'b1, 32, 24'hFFFFFF);
        check("ovr_count", n_ovr - o0, 1);
        check("ovr_valid_held", valid, 1'b1);
        check("ovr_left", left_data, 24'h7FFFFF);
        check("ovr_right", right_data, 24'hFFFFFF);
        ready_mode = 1;
        repeat (3) @(negedge clk);
        #1 check("ovr_valid_dropped", valid, 1'b0);

        // Short left slot of 16 sclk.
        v0 = n_valid_cyc; f0 = n_ferr;
        wl = DW'($urandom); wr = DW'($urandom);
        send_slot(1'b0, 16, DW'($urandom));
        send_slot(1'b1, 32, DW'($urandom));
        send_slot(1'b0, 32, wl);
        send_slot(1'b1, 32, wr);
        check("short_frame_errs", n_ferr - f0, 1);
        check("short_valid_cycles", n_valid_cyc - v0, 1);
        check("short_left", seen_l, wl);
        check("short_right", seen_r, wr);

        // Reset released during a right slot.
        v0 = n_valid_cyc;
        wl = DW'($urandom); wr = DW'($urandom);
        send_slot(1'b1, 32, DW'($urandom), 10);
        send_slot(1'b0, 32, wl);
        send_slot(1'b1, 32, wr);
        check("midright_valid_cycles", n_valid_cyc - v0, 1);
        check("midright_left", seen_l, wl);
        check("midright_right", seen_r, wr);

        // Reset mid left word while a frame is held.
        ready_mode = 0;
        send_slot(1'b0, 32, DW'($urandom));
        send_slot(1'b1, 32, DW'($urandom));
        send_slot(1'b0, 32, DW'($urandom), 10);
        check("midword_pre_valid", pre_valid, 1'b1);
        ready_mode = 1;
        wl = DW'($urandom); wr = DW'($urandom);
        send_slot(1'b1, 32, DW'($urandom));
        send_slot(1'b0, 32, wl);
        send_slot(1'b1, 32, wr);
        check("midword_left", seen_l, wl);
        check("midword_right", seen_r, wr);

        // Frame whose values exercise MSB/LSB alignment.
        send_slot(1'b0, 32, 24'hC00003);
        send_slot(1'b1, 32, 24'h3FFFFC);
        check("align_left", seen_l, 24'hC00003);
        check("align_right", seen_r, 24'h3FFFFC);

        // Random words, random ready, occasional odd slot lengths.
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            send_slot(1'b0, ($urandom_range(0, 4) == 0) ? $urandom_range(8, 33) : 32,
                      DW'($urandom));
            send_slot(1'b1, ($urandom_range(0, 4) == 0) ? $urandom_range(8, 33) : 32,
                      DW'($urandom));
        end
        ready_mode = 1;
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
